// File: rtl/pulse_mode_sequencer.sv
// rtl/pulse_mode_sequencer.sv - front-panel pulse function selector with glitch-free switchover
//
// Steps through NUM_MODES pulse-generator functions on debounced next/prev
// button presses, routes the selected function's pulse channels to the
// output pins and lights a one-hot LED for the current mode. A mode change
// waits for the outgoing channels to finish their high phase (bounded by
// DRAIN_MAX), holds the outputs low for GAP_CYCLES, and strobes the incoming
// function's reset on the first gap cycle so it starts a fresh period.
//
// Ports:
//   sysclk       system clock
//   reset        synchronous active-high reset
//   bt_next      debounced level, advance one mode
//   bt_prev      debounced level, go back one mode
//   mode_pulses  function pulse inputs, bit m*NUM_CH+c = mode m, channel c
//   pulse_out    routed, registered pulse channels
//   leds         one-hot current mode
//   mode         current mode index
//   mode_rst     one-cycle reset strobe to the incoming function
//   switching    high while draining or in the forced-low gap

module pulse_mode_sequencer #(
   parameter int                            NUM_MODES    = 4,
   parameter int                            MODE_W       = 2,
   parameter int                            NUM_CH       = 2,
   parameter logic [NUM_MODES*NUM_CH-1:0]   CH_USED_MASK = 8'b11_11_01_01,
   parameter int                            GAP_CYCLES   = 4,
   parameter int                            DRAIN_MAX    = 1000,
   parameter int                            RESET_MODE   = 0
) (
   input  logic                          sysclk,
   input  logic                          reset,
   input  logic                          bt_next,
   input  logic                          bt_prev,
   input  logic [NUM_MODES*NUM_CH-1:0]   mode_pulses,
   output logic [NUM_CH-1:0]             pulse_out,
   output logic [NUM_MODES-1:0]          leds,
   output logic [MODE_W-1:0]             mode,
   output logic [NUM_MODES-1:0]          mode_rst,
   output logic                          switching
);

   localparam int MODE_SLOTS = 2 ** MODE_W;
   localparam int DRAIN_W    = (DRAIN_MAX > 1) ? $clog2(DRAIN_MAX) : 1;
   localparam int GAP_W      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   localparam logic [MODE_W-1:0]  RESET_IDX  = MODE_W'(RESET_MODE);
   localparam logic [MODE_W-1:0]  LAST_IDX   = MODE_W'(NUM_MODES - 1);
   localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_MAX - 1);
   localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   state_t               state_q,     state_d;
   logic [MODE_W-1:0]    mode_q,      mode_d;
   logic [MODE_W-1:0]    target_q,    target_d;
   logic [DRAIN_W-1:0]   drain_cnt_q, drain_cnt_d;
   logic [GAP_W-1:0]     gap_cnt_q,   gap_cnt_d;
   logic                 next_q,      next_d;
   logic                 prev_q,      prev_d;
   logic [NUM_CH-1:0]    pulse_q,     pulse_d;
   logic [NUM_MODES-1:0] mode_rst_q,  mode_rst_d;

   // Per-mode masked channel lanes. Slots beyond NUM_MODES exist only so the
   // lane table can be indexed directly by a MODE_W-bit index; they read 0.
   logic [NUM_CH-1:0]    lane [MODE_SLOTS];
   logic [NUM_CH-1:0]    routed;
   logic [NUM_MODES-1:0] mode_onehot;
   logic [NUM_MODES-1:0] target_onehot;

   for (genvar m = 0; m < MODE_SLOTS; m++) begin : g_lane
      if (m < NUM_MODES) begin : g_used
         assign lane[m] = mode_pulses[m*NUM_CH +: NUM_CH] & CH_USED_MASK[m*NUM_CH +: NUM_CH];
      end else begin : g_unused
         assign lane[m] = '0;
      end
   end

   for (genvar m = 0; m < NUM_MODES; m++) begin : g_onehot
      assign mode_onehot[m]   = (mode_q   == MODE_W'(m));
      assign target_onehot[m] = (target_q == MODE_W'(m));
   end

   assign routed = lane[mode_q];

   logic              rise_next;
   logic              rise_prev;
   logic [MODE_W-1:0] next_idx;
   logic [MODE_W-1:0] prev_idx;

   assign rise_next = bt_next & ~next_q;
   assign rise_prev = bt_prev & ~prev_q;
   assign next_idx  = (mode_q == LAST_IDX) ? '0 : mode_q + 1'b1;
   assign prev_idx  = (mode_q == '0) ? LAST_IDX : mode_q - 1'b1;

   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      target_d    = target_q;
      drain_cnt_d = drain_cnt_q;
      gap_cnt_d   = gap_cnt_q;
      next_d      = bt_next;
      prev_d      = bt_prev;
      pulse_d     = routed;
      mode_rst_d  = '0;

      case (state_q)
         ST_RUN: begin
            // Simultaneous next+prev rises cancel; exactly one must rise.
            if (rise_next ^ rise_prev) begin
               target_d    = rise_next ? next_idx : prev_idx;
               drain_cnt_d = '0;
               state_d     = ST_DRAIN;
            end
         end

         ST_DRAIN: begin
            // Old mode keeps driving until its routed channels are all low,
            // or the timeout cuts them; either way the outputs go low from
            // the next cycle and the new mode takes over.
            if ((routed == '0) || (drain_cnt_q == DRAIN_LAST)) begin
               state_d    = ST_GAP;
               mode_d     = target_q;
               mode_rst_d = target_onehot;
               pulse_d    = '0;
               gap_cnt_d  = '0;
            end else begin
               drain_cnt_d = drain_cnt_q + 1'b1;
            end
         end

         ST_GAP: begin
            pulse_d = '0;
            if (gap_cnt_q == GAP_LAST) begin
               state_d = ST_RUN;
            end else begin
               gap_cnt_d = gap_cnt_q + 1'b1;
            end
         end

         default: begin
            state_d = ST_RUN;
            pulse_d = '0;
         end
      endcase
   end

   always_ff @(posedge sysclk) begin
      if (reset) begin
         state_q     <= ST_RUN;
         mode_q      <= RESET_IDX;
         target_q    <= RESET_IDX;
         drain_cnt_q <= '0;
         gap_cnt_q   <= '0;
         next_q      <= 1'b0;
         prev_q      <= 1'b0;
         pulse_q     <= '0;
         mode_rst_q  <= '0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         target_q    <= target_d;
         drain_cnt_q <= drain_cnt_d;
         gap_cnt_q   <= gap_cnt_d;
         next_q      <= next_d;
         prev_q      <= prev_d;
         pulse_q     <= pulse_d;
         mode_rst_q  <= mode_rst_d;
      end
   end

   assign pulse_out = pulse_q;
   assign leds      = mode_onehot;
   assign mode      = mode_q;
   assign mode_rst  = mode_rst_q;
   assign switching = (state_q != ST_RUN);

endmodule
